// File: rtl/digit_overlay_if.sv
// Signal bundle between the video timing / font ROM / field-write side and
// digit_overlay_ctrl. The master drives pixel coordinates, ROM data and write requests.
interface digit_overlay_if;
  logic        video_on;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic [7:0]  rom_data;
  logic [8:0]  rom_addr;
  logic        wr_req;
  logic [1:0]  wr_sel;
  logic [23:0] wr_data;
  logic        wr_ack;
  logic        busy;
  logic        pix_on;
  logic [1:0]  pix_field;

  modport master (
    output video_on, pixel_x, pixel_y, rom_data, wr_req, wr_sel, wr_data,
    input  rom_addr, wr_ack, busy, pix_on, pix_field
  );

  modport slave (
    input  video_on, pixel_x, pixel_y, rom_data, wr_req, wr_sel, wr_data,
    output rom_addr, wr_ack, busy, pix_on, pix_field
  );
endinterface

// File: rtl/digit_overlay_ctrl.sv
// Draws the date/hour/timer BCD fields through the shared font ROM with a fixed
// two-clock pixel latency; field writes are shadowed and committed in vertical blank.
module digit_overlay_ctrl #(
  parameter logic [4:0] DIGIT_BASE = 5'b10000,
  parameter logic [9:0] X0         = 10'd208,
  parameter logic [9:0] X1         = 10'd288,
  parameter logic [9:0] X2         = 10'd384,
  parameter logic [9:0] Y_DATE     = 10'd64,
  parameter logic [9:0] Y_HOUR     = 10'd224,
  parameter logic [9:0] Y_TIMER    = 10'd384
) (
  input logic            clk,
  input logic            rst_n,
  digit_overlay_if.slave bus
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  localparam logic [9:0] SPAN    = 10'd31;
  localparam logic [9:0] HALF    = 10'd16;
  localparam logic [9:0] BLANK_Y = 10'd480;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_ack_nxt;
  logic        w_load;
  logic        w_commit;

  logic [23:0] r_act_date;
  logic [23:0] r_act_hour;
  logic [23:0] r_act_timer;
  logic [23:0] r_shadow;
  logic [1:0]  r_sel;
  logic        r_wr_ack;
  logic        r_busy;

  logic [1:0]  w_row_field;
  logic        w_row_hit;
  logic [1:0]  w_pair;
  logic        w_right;
  logic        w_col_hit;
  logic [2:0]  w_cell;
  logic [23:0] w_word;
  logic [3:0]  w_digit;
  logic        w_hit;
  logic [4:0]  w_code;
  logic [1:0]  w_field;

  logic [8:0]  r_rom_addr;
  logic [1:0]  r_field_d;
  logic [2:0]  r_bit_d;
  logic        r_video_d;
  logic        r_hit_d;
  logic        w_ink;
  logic        r_pix_on;
  logic [1:0]  r_pix_field;

  // Stage 0: locate the pixel in a field row and digit cell, then pick its glyph code
  always_comb begin
    w_row_field = 2'd3;
    w_row_hit   = 1'b0;
    w_pair      = 2'd0;
    w_right     = 1'b0;
    w_col_hit   = 1'b0;
    w_word      = 24'd0;
    w_digit     = 4'd0;
    w_hit       = 1'b0;
    w_code      = 5'd0;
    w_field     = 2'd3;

    if ((bus.pixel_y >= Y_DATE) && (bus.pixel_y <= Y_DATE + SPAN)) begin
      w_row_field = 2'd0;
      w_row_hit   = 1'b1;
    end else if ((bus.pixel_y >= Y_HOUR) && (bus.pixel_y <= Y_HOUR + SPAN)) begin
      w_row_field = 2'd1;
      w_row_hit   = 1'b1;
    end else if ((bus.pixel_y >= Y_TIMER) && (bus.pixel_y <= Y_TIMER + SPAN)) begin
      w_row_field = 2'd2;
      w_row_hit   = 1'b1;
    end else begin
      w_row_field = 2'd3;
      w_row_hit   = 1'b0;
    end

    if ((bus.pixel_x >= X0) && (bus.pixel_x <= X0 + SPAN)) begin
      w_pair    = 2'd0;
      w_right   = (bus.pixel_x >= X0 + HALF);
      w_col_hit = 1'b1;
    end else if ((bus.pixel_x >= X1) && (bus.pixel_x <= X1 + SPAN)) begin
      w_pair    = 2'd1;
      w_right   = (bus.pixel_x >= X1 + HALF);
      w_col_hit = 1'b1;
    end else if ((bus.pixel_x >= X2) && (bus.pixel_x <= X2 + SPAN)) begin
      w_pair    = 2'd2;
      w_right   = (bus.pixel_x >= X2 + HALF);
      w_col_hit = 1'b1;
    end else begin
      w_pair    = 2'd0;
      w_right   = 1'b0;
      w_col_hit = 1'b0;
    end

    w_cell = {w_pair, w_right};

    case (w_row_field)
      2'd0:    w_word = r_act_date;
      2'd1:    w_word = r_act_hour;
      2'd2:    w_word = r_act_timer;
      default: w_word = 24'd0;
    endcase

    case (w_cell)
      3'd0:    w_digit = w_word[23:20];
      3'd1:    w_digit = w_word[19:16];
      3'd2:    w_digit = w_word[15:12];
      3'd3:    w_digit = w_word[11:8];
      3'd4:    w_digit = w_word[7:4];
      3'd5:    w_digit = w_word[3:0];
      default: w_digit = 4'd0;
    endcase

    // Non-decimal nibbles render as the blank glyph and never produce ink
    w_hit = w_row_hit & w_col_hit & (w_digit <= 4'd9);

    if (w_hit) begin
      w_code = DIGIT_BASE + {1'b0, w_digit};
    end else begin
      w_code = 5'd0;
    end

    if (w_row_hit && w_col_hit) begin
      w_field = w_row_field;
    end else begin
      w_field = 2'd3;
    end
  end

  // Stage 1: present the ROM address and carry pixel attributes alongside it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rom_addr <= 9'd0;
      r_field_d  <= 2'd3;
      r_bit_d    <= 3'd0;
      r_video_d  <= 1'b0;
      r_hit_d    <= 1'b0;
    end else begin
      r_rom_addr <= {w_code, bus.pixel_y[4:1]};
      r_field_d  <= w_field;
      r_bit_d    <= bus.pixel_x[3:1];
      r_video_d  <= bus.video_on;
      r_hit_d    <= w_hit;
    end
  end

  // Glyph bit 0 is the leftmost pixel, stored in the ROM word's MSB
  assign w_ink = bus.rom_data[~r_bit_d];

  // Stage 2: register the ink bit from the returned glyph row
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pix_on    <= 1'b0;
      r_pix_field <= 2'd3;
    end else begin
      r_pix_on    <= r_video_d & r_hit_d & w_ink;
      r_pix_field <= r_field_d;
    end
  end

  // Write FSM next state: accept into the shadow, commit once in vertical blank
  always_comb begin
    w_state_nxt = r_state;
    w_ack_nxt   = 1'b0;
    w_load      = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.wr_req) begin
          w_ack_nxt = 1'b1;
          if (bus.wr_sel != 2'd3) begin
            w_load      = 1'b1;
            w_state_nxt = ST_HOLD;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (bus.pixel_y >= BLANK_Y) begin
          w_commit    = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_HOLD;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Write FSM state and handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_wr_ack <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_wr_ack <= w_ack_nxt;
      r_busy   <= (w_state_nxt == ST_HOLD);
    end
  end

  // Shadow capture on accept; active fields change only on the commit edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow    <= 24'd0;
      r_sel       <= 2'd0;
      r_act_date  <= 24'd0;
      r_act_hour  <= 24'd0;
      r_act_timer <= 24'd0;
    end else begin
      if (w_load) begin
        r_shadow <= bus.wr_data;
        r_sel    <= bus.wr_sel;
      end
      if (w_commit) begin
        case (r_sel)
          2'd0:    r_act_date  <= r_shadow;
          2'd1:    r_act_hour  <= r_shadow;
          2'd2:    r_act_timer <= r_shadow;
          default: r_act_date  <= r_act_date;
        endcase
      end
    end
  end

  assign bus.rom_addr  = r_rom_addr;
  assign bus.pix_on    = r_pix_on;
  assign bus.pix_field = r_pix_field;
  assign bus.wr_ack    = r_wr_ack;
  assign bus.busy      = r_busy;

endmodule
